axi_lite_csr_slave: RTL and testbench

- AXI4-Lite responder terminating the CPU/config master's control path into DMA_SG_Engine.
- Implements the engine CSR bank: control, status, descriptor ring head/tail, interrupt status/enable, and version.
- Drives engine control outputs and a level interrupt.
- One outstanding write and one outstanding read; no IDs, no bursts.

---
 rtl/axi_lite_csr_slave_if.sv | 35 +++
 rtl/axi_lite_csr_slave.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_axi_lite_csr_slave.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_csr_slave_if.sv
// AXI4-Lite bus bundle between the config master and the DMA CSR slave.
// Latency: none, wires only.
// Backpressure: standard valid/ready on AW, W, B, AR and R channels.
interface axi_lite_csr_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_csr_slave.sv
// AXI4-Lite CSR bank for the DMA scatter-gather engine (control, ring pointers, irq).
// Latency: write commits 1 cycle after both AW and W are held; read data 1 cycle after AR.
// Backpressure: one write and one read outstanding; readies drop until B/R handshake completes.
module axi_lite_csr_slave #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] VERSION    = 32'h0001_0000
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    axi_lite_csr_slave_if.slave   s_axi,
    output logic                  ctrl_run_o,
    output logic                  soft_rst_o,
    output logic [31:0]           desc_head_o,
    output logic [31:0]           desc_tail_o,
    output logic                  tail_wr_o,
    input  logic [31:0]           sts_i,
    input  logic [1:0]            irq_set_i,
    output logic                  irq_o
);
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RESP = 1'b1;

    localparam logic [9:0] IDX_CTRL    = 10'd0;
    localparam logic [9:0] IDX_STATUS  = 10'd1;
    localparam logic [9:0] IDX_HEAD    = 10'd2;
    localparam logic [9:0] IDX_TAIL    = 10'd3;
    localparam logic [9:0] IDX_IRQ_STS = 10'd4;
    localparam logic [9:0] IDX_IRQ_EN  = 10'd5;
    localparam logic [9:0] IDX_VERSION = 10'd6;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Descriptor pointers are 64-byte aligned; low six bits never hold state.
    localparam logic [31:0] PTR_MASK = 32'hFFFF_FFC0;

    // Only the word index [11:2] decodes; the remaining address bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi.awaddr[ADDR_WIDTH-1:12], s_axi.awaddr[1:0],
                                s_axi.araddr[ADDR_WIDTH-1:12], s_axi.araddr[1:0]};

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    // Write channel state
    logic [0:0]              wstate_q, wstate_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q, w_held_d;
    logic [9:0]              awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;

    // CSR contents
    logic                    run_q, run_d;
    logic                    gen_q, gen_d;
    logic                    soft_rst_q, soft_rst_d;
    logic [31:0]             head_q, head_d;
    logic [31:0]             tail_q, tail_d;
    logic                    tail_wr_q, tail_wr_d;
    logic [1:0]              irq_sts_q, irq_sts_d;
    logic [1:0]              irq_en_q, irq_en_d;
    logic                    irq_q, irq_d;

    // Read channel state
    logic [0:0]              rstate_q, rstate_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;

    // Scratch for the write path
    logic                    aw_hs, w_hs, have_aw, have_w, commit;
    logic [9:0]              wr_idx;
    logic [31:0]             wr_dat;
    logic [3:0]              wr_strb;
    logic [1:0]              irq_clr;

    // Write handshakes, commit and all CSR updates, including irq status set/clear.
    always_comb begin
        wstate_d   = wstate_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        run_d      = run_q;
        gen_d      = gen_q;
        soft_rst_d = 1'b0;
        head_d     = head_q;
        tail_d     = tail_q;
        tail_wr_d  = 1'b0;
        irq_en_d   = irq_en_q;
        irq_clr    = 2'b00;
        commit     = 1'b0;

        aw_hs   = s_axi.awvalid & awready_q;
        w_hs    = s_axi.wvalid & wready_q;
        have_aw = aw_held_q | aw_hs;
        have_w  = w_held_q | w_hs;
        // A beat accepted this cycle is used directly so AW+W together commit at once.
        wr_idx  = aw_held_q ? awaddr_q : s_axi.awaddr[11:2];
        wr_dat  = w_held_q ? wdata_q : s_axi.wdata;
        wr_strb = w_held_q ? wstrb_q : s_axi.wstrb;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi.awaddr[11:2];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi.wdata;
            wstrb_d  = s_axi.wstrb;
        end

        case (wstate_q)
            W_IDLE: begin
                if (have_aw && have_w) begin
                    commit    = 1'b1;
                    wstate_d  = W_RESP;
                    bvalid_d  = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                end else begin
                    awready_d = ~have_aw;
                    wready_d  = ~have_w;
                end
            end
            W_RESP: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                if (s_axi.bready) begin
                    wstate_d  = W_IDLE;
                    bvalid_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: wstate_d = W_IDLE;
        endcase

        if (commit) begin
            bresp_d = RESP_OKAY;
            case (wr_idx)
                IDX_CTRL: begin
                    if (wr_strb[0]) begin
                        // Soft reset also stops the engine in the same cycle.
                        run_d      = wr_dat[0] & ~wr_dat[1];
                        gen_d      = wr_dat[2];
                        soft_rst_d = wr_dat[1];
                    end
                end
                IDX_HEAD: head_d = lane_merge(head_q, wr_dat, wr_strb) & PTR_MASK;
                IDX_TAIL: begin
                    tail_d    = lane_merge(tail_q, wr_dat, wr_strb) & PTR_MASK;
                    tail_wr_d = |wr_strb;
                end
                IDX_IRQ_STS: if (wr_strb[0]) irq_clr = wr_dat[1:0];
                IDX_IRQ_EN:  if (wr_strb[0]) irq_en_d = wr_dat[1:0];
                default:     bresp_d = RESP_SLVERR;
            endcase
        end

        // New causes win over a simultaneous W1C.
        irq_sts_d = (irq_sts_q & ~irq_clr) | irq_set_i;
        irq_d     = gen_d & |(irq_sts_d & irq_en_d);
    end

    // Read handshake and register read mux; sources are pre-commit values.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_axi.arvalid && arready_q) begin
                    rstate_d  = R_RESP;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rresp_d   = RESP_OKAY;
                    case (s_axi.araddr[11:2])
                        IDX_CTRL:    rdata_d = {29'd0, gen_q, 1'b0, run_q};
                        IDX_STATUS:  rdata_d = sts_i;
                        IDX_HEAD:    rdata_d = head_q;
                        IDX_TAIL:    rdata_d = tail_q;
                        IDX_IRQ_STS: rdata_d = {30'd0, irq_sts_q};
                        IDX_IRQ_EN:  rdata_d = {30'd0, irq_en_q};
                        IDX_VERSION: rdata_d = VERSION;
                        default: begin
                            rdata_d = '0;
                            rresp_d = RESP_SLVERR;
                        end
                    endcase
                end
            end
            R_RESP: begin
                arready_d = 1'b0;
                if (s_axi.rready) begin
                    rstate_d  = R_IDLE;
                    rvalid_d  = 1'b0;
                    rdata_d   = '0;
                    rresp_d   = RESP_OKAY;
                    arready_d = 1'b1;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // State registers; reset abandons any transaction in flight.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wstate_q   <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            run_q      <= 1'b0;
            gen_q      <= 1'b0;
            soft_rst_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            tail_wr_q  <= 1'b0;
            irq_sts_q  <= '0;
            irq_en_q   <= '0;
            irq_q      <= 1'b0;
            rstate_q   <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wstate_q   <= wstate_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            run_q      <= run_d;
            gen_q      <= gen_d;
            soft_rst_q <= soft_rst_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            tail_wr_q  <= tail_wr_d;
            irq_sts_q  <= irq_sts_d;
            irq_en_q   <= irq_en_d;
            irq_q      <= irq_d;
            rstate_q   <= rstate_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign ctrl_run_o    = run_q;
    assign soft_rst_o    = soft_rst_q;
    assign desc_head_o   = head_q;
    assign desc_tail_o   = tail_q;
    assign tail_wr_o     = tail_wr_q;
    assign irq_o         = irq_q;
endmodule

// File: tb/tb_axi_lite_csr_slave.sv
// Self-checking bench for axi_lite_csr_slave: directed scenarios plus random traffic.
// Expected values come from a register-level model of the CSR map kept here.
// All sampling happens 1 time unit after the rising edge.
module tb_axi_lite_csr_slave;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        ctrl_run_o, soft_rst_o, tail_wr_o, irq_o;
    logic [31:0] desc_head_o, desc_tail_o;
    logic [31:0] sts_i = '0;
    logic [1:0]  irq_set_i = '0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 ACLK = ~ACLK;

    axi_lite_csr_slave_if bus ();

    axi_lite_csr_slave dut (
        .ACLK(ACLK), .ARESET(ARESET), .s_axi(bus),
        .ctrl_run_o(ctrl_run_o), .soft_rst_o(soft_rst_o),
        .desc_head_o(desc_head_o), .desc_tail_o(desc_tail_o),
        .tail_wr_o(tail_wr_o), .sts_i(sts_i), .irq_set_i(irq_set_i), .irq_o(irq_o)
    );

    // ---------------- reference model ----------------
    logic        m_run, m_gen;
    logic [31:0] m_head, m_tail;
    logic [1:0]  m_irq_sts, m_irq_en, last_set;

    task automatic model_reset();
        m_run = 0; m_gen = 0; m_head = 0; m_tail = 0;
        m_irq_sts = 0; m_irq_en = 0; last_set = 0;
    endtask

    // Interrupt causes are latched at every clock edge out of reset.
    always @(posedge ACLK) begin
        last_set = irq_set_i;
        if (!ARESET) m_irq_sts = m_irq_sts | irq_set_i;
    end

    function automatic logic m_irq();
        return m_gen & |(m_irq_sts & m_irq_en);
    endfunction

    function automatic logic [31:0] strobe_bytes(input logic [31:0] o, input logic [31:0] n,
                                                 input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp, output logic srst, output logic twr);
        resp = 2'b00; srst = 0; twr = 0;
        case (a[11:2])
            10'd0: if (s[0]) begin m_run = d[0] & ~d[1]; m_gen = d[2]; srst = d[1]; end
            10'd2: m_head = strobe_bytes(m_head, d, s) & 32'hFFFF_FFC0;
            10'd3: begin m_tail = strobe_bytes(m_tail, d, s) & 32'hFFFF_FFC0; twr = |s; end
            10'd4: if (s[0]) m_irq_sts = (m_irq_sts & ~d[1:0]) | last_set;
            10'd5: if (s[0]) m_irq_en = d[1:0];
            default: resp = 2'b10;
        endcase
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, output logic [1:0] resp);
        resp = 2'b00;
        case (a[11:2])
            10'd0: return {29'd0, m_gen, 1'b0, m_run};
            10'd1: return sts_i;
            10'd2: return m_head;
            10'd3: return m_tail;
            10'd4: return {30'd0, m_irq_sts};
            10'd5: return {30'd0, m_irq_en};
            10'd6: return 32'h0001_0000;
            default: begin resp = 2'b10; return 32'd0; end
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_rdy"}, {29'd0, bus.awready, bus.wready, bus.arready}, 0);
        chk({tag, "_vld"}, {30'd0, bus.bvalid, bus.rvalid}, 0);
        chk({tag, "_resp"}, {28'd0, bus.bresp, bus.rresp}, 0);
        chk({tag, "_rdata"}, bus.rdata, 0);
        chk({tag, "_head"}, desc_head_o, 0);
        chk({tag, "_tail"}, desc_tail_o, 0);
        chk({tag, "_pulses"}, {28'd0, ctrl_run_o, soft_rst_o, tail_wr_o, irq_o}, 0);
    endtask

    // ---------------- bus drivers ----------------
    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        logic rdy;
        bus.awaddr = a; bus.awvalid = 1;
        do begin rdy = bus.awready; tick(); n++; end while (!rdy && n < 50);
        if (!rdy) chk("aw_timeout", 0, 1);
        bus.awvalid = 0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        logic rdy;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1;
        do begin rdy = bus.wready; tick(); n++; end while (!rdy && n < 50);
        if (!rdy) chk("w_timeout", 0, 1);
        bus.wvalid = 0;
    endtask

    // mode 0: AW and W together; 1: W one cycle late; 2: AW one cycle late.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int mode, input int bdly);
        logic [1:0] er;
        logic esr, etw;
        fork
            begin if (mode == 2) tick(); send_aw(a); end
            begin if (mode == 1) tick(); send_w(d, s); end
        join
        model_write(a, d, s, er, esr, etw);
        chk("bvalid_rise", bus.bvalid, 1);
        chk("bresp", bus.bresp, er);
        chk("soft_rst_pulse", soft_rst_o, esr);
        chk("tail_wr_pulse", tail_wr_o, etw);
        chk("ctrl_run", ctrl_run_o, m_run);
        chk("desc_head", desc_head_o, m_head);
        chk("desc_tail", desc_tail_o, m_tail);
        chk("irq_after_wr", irq_o, m_irq());
        chk("w_ready_busy", {bus.awready, bus.wready}, 0);
        tick();
        chk("pulses_end", {soft_rst_o, tail_wr_o}, 0);
        for (int i = 1; i < bdly; i++) begin
            chk("bvalid_hold", bus.bvalid, 1);
            chk("bresp_hold", bus.bresp, er);
            tick();
        end
        chk("bvalid_pre_hs", bus.bvalid, 1);
        bus.bready = 1;
        tick();
        bus.bready = 0;
        chk("bvalid_fall", bus.bvalid, 0);
        chk("w_ready_back", {bus.awready, bus.wready}, 2'b11);
    endtask

    task automatic axi_read(input logic [31:0] a, input int rdly);
        logic [1:0]  er;
        logic [31:0] ed;
        int n = 0;
        logic rdy;
        ed = model_read(a, er);
        bus.araddr = a; bus.arvalid = 1;
        do begin rdy = bus.arready; tick(); n++; end while (!rdy && n < 50);
        if (!rdy) chk("ar_timeout", 0, 1);
        bus.arvalid = 0;
        chk("rvalid_rise", bus.rvalid, 1);
        chk("arready_busy", bus.arready, 0);
        chk("rdata", bus.rdata, ed);
        chk("rresp", bus.rresp, er);
        for (int i = 0; i < rdly; i++) begin
            tick();
            chk("rdata_hold", bus.rdata, ed);
            chk("rvalid_hold", bus.rvalid, 1);
        end
        bus.rready = 1;
        tick();
        bus.rready = 0;
        chk("rvalid_fall", bus.rvalid, 0);
        chk("arready_back", bus.arready, 1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [9:0] idx;
        int pick;
        pick = $urandom_range(0, 8);
        idx = (pick <= 6) ? 10'(pick) : ((pick == 7) ? 10'h010 : 10'($urandom_range(7, 1023)));
        return {20'($urandom), idx, 2'($urandom)};
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        bus.awaddr = 0; bus.awvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wvalid = 0;
        bus.bready = 0; bus.araddr = 0; bus.arvalid = 0; bus.rready = 0;
        model_reset();
        #1;
        chk_outputs_zero("reset");
        tick(); tick();
        ARESET = 0;
        chk("rdy_before_edge", {bus.awready, bus.wready, bus.arready}, 0);
        tick();
        chk("rdy_after_edge", {bus.awready, bus.wready, bus.arready}, 3'b111);

        axi_read(32'h18, 0);
        axi_write(32'h08, 32'hDEAD_BEFF, 4'hF, 1, 3);
        axi_read(32'h08, 2);
        chk("head_aligned", desc_head_o, 32'hDEAD_BEC0);

        axi_write(32'h0C, 32'h0000_1040, 4'b0011, 0, 0);
        chk("tail_val", desc_tail_o, 32'h0000_1040);
        axi_write(32'h0C, 32'hFFFF_FFFF, 4'b0000, 2, 0);
        chk("tail_unchanged", desc_tail_o, 32'h0000_1040);

        axi_write(32'h14, 32'h3, 4'hF, 0, 0);
        axi_write(32'h00, 32'h4, 4'hF, 0, 0);
        irq_set_i = 2'b01;
        tick();
        irq_set_i = 2'b00;
        chk("irq_raise", irq_o, 1);
        irq_set_i = 2'b01;
        axi_write(32'h10, 32'h1, 4'hF, 0, 0);
        irq_set_i = 2'b00;
        axi_read(32'h10, 0);
        chk("irq_set_wins", irq_o, 1);
        axi_write(32'h10, 32'h1, 4'hF, 0, 1);
        chk("irq_cleared", irq_o, 0);

        axi_read(32'h40, 1);
        sts_i = 32'hCAFE_0123;
        axi_write(32'h04, 32'h1234_5678, 4'hF, 0, 0);
        axi_read(32'h04, 0);
        axi_write(32'h00, 32'h1, 4'hF, 0, 0);
        chk("run_set", ctrl_run_o, 1);
        axi_write(32'h00, 32'h3, 4'hF, 2, 0);
        axi_read(32'h00, 0);

        // Read accepted in the same cycle a W1C commits sees the pre-clear value.
        irq_set_i = 2'b11;
        tick();
        irq_set_i = 2'b00;
        tick();
        fork
            axi_write(32'h10, 32'h3, 4'hF, 0, 0);
            axi_read(32'h10, 0);
        join
        axi_read(32'h10, 0);

        for (int t = 0; t < 150; t++) begin
            sts_i = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                irq_set_i = 2'($urandom);
                tick();
                irq_set_i = 2'b00;
                chk("rand_irq", irq_o, m_irq());
            end
            if ($urandom_range(0, 1) == 0)
                axi_write(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
            else
                axi_read(rand_addr(), $urandom_range(0, 2));
        end

        // Reset with a B and an R response both pending.
        bus.awaddr = 32'h08; bus.awvalid = 1; bus.wdata = 32'h5555_5540; bus.wstrb = 4'hF;
        bus.wvalid = 1; bus.araddr = 32'h18; bus.arvalid = 1;
        tick();
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        tick();
        chk("pending_b_r", {bus.bvalid, bus.rvalid}, 2'b11);
        ARESET = 1;
        #1;
        model_reset();
        chk_outputs_zero("mid_reset");
        tick();
        ARESET = 0;
        tick();
        chk("post_reset_rdy", {bus.awready, bus.wready, bus.arready}, 3'b111);
        chk("post_reset_vld", {bus.bvalid, bus.rvalid}, 0);
        axi_read(32'h08, 0);
        axi_write(32'h08, 32'h0000_0080, 4'hF, 0, 0);
        axi_read(32'h08, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
